// File: rtl/vrb_pkg.sv
// rtl/vrb_pkg.sv - shared types and constants for the VRB 2-master arbiter
// Contents: FSM state enum, master-id constants.
package vrb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } vrb_state_e;

  localparam logic M_LSU = 1'b0;  // execute-stage load/store master (m0)
  localparam logic M_IFU = 1'b1;  // instruction-fetch master (m1)

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-input fixed-priority / round-robin picker
// Ports:
//   i_req   in  2  request vector, bit X = master X
//   i_last  in  1  id of the master served last
//   i_fixed in  1  1: master 0 wins ties; 0: tie goes to the master that is not i_last
//   o_gnt   out 2  one-hot grant (zero when no request)
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_fixed,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_fixed || i_last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/vrb_arbiter.sv
// rtl/vrb_arbiter.sv - VRB bus 2-master to 1-slave arbiter, one transaction in flight
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_mX_cmd_valid/addr/read/wdata/wmask  master X request (held until its response)
//   o_mX_cmd_ready                  1-cycle pulse when the slave accepts master X's command
//   o_mX_rsp_valid/err/rdata        response to master X (zero unless X is granted and responding)
//   o_s_cmd_valid/addr/read/wdata/wmask   registered command to the slave
//   i_s_cmd_ready                   slave accepts command
//   i_s_rsp_valid/err/rdata         slave response
module vrb_arbiter
  import vrb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int PRIO_FIXED = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_m0_cmd_valid,
  input  logic [AW-1:0]   i_m0_cmd_addr,
  input  logic            i_m0_cmd_read,
  input  logic [DW-1:0]   i_m0_cmd_wdata,
  input  logic [DW/8-1:0] i_m0_cmd_wmask,
  output logic            o_m0_cmd_ready,
  output logic            o_m0_rsp_valid,
  output logic            o_m0_rsp_err,
  output logic [DW-1:0]   o_m0_rsp_rdata,
  input  logic            i_m1_cmd_valid,
  input  logic [AW-1:0]   i_m1_cmd_addr,
  input  logic            i_m1_cmd_read,
  input  logic [DW-1:0]   i_m1_cmd_wdata,
  input  logic [DW/8-1:0] i_m1_cmd_wmask,
  output logic            o_m1_cmd_ready,
  output logic            o_m1_rsp_valid,
  output logic            o_m1_rsp_err,
  output logic [DW-1:0]   o_m1_rsp_rdata,
  output logic            o_s_cmd_valid,
  input  logic            i_s_cmd_ready,
  output logic [AW-1:0]   o_s_cmd_addr,
  output logic            o_s_cmd_read,
  output logic [DW-1:0]   o_s_cmd_wdata,
  output logic [DW/8-1:0] o_s_cmd_wmask,
  input  logic            i_s_rsp_valid,
  input  logic            i_s_rsp_err,
  input  logic [DW-1:0]   i_s_rsp_rdata
);

  vrb_state_e      r_state;
  logic            r_grant;
  logic            r_rr_last;
  logic            r_s_cmd_valid;
  logic [AW-1:0]   r_s_cmd_addr;
  logic            r_s_cmd_read;
  logic [DW-1:0]   r_s_cmd_wdata;
  logic [DW/8-1:0] r_s_cmd_wmask;

  logic [1:0]      w_gnt;
  logic            w_timeout;
  logic            w_accept;
  logic            w_rsp_fire;
  logic            w_rsp_err;
  logic [DW-1:0]   w_rsp_rdata;

  rr_arb2 u_rr_arb2 (
    .i_req   ({i_m1_cmd_valid, i_m0_cmd_valid}),
    .i_last  (r_rr_last),
    .i_fixed (PRIO_FIXED != 0),
    .o_gnt   (w_gnt)
  );

  assign w_accept   = (r_state == ST_CMD) && i_s_cmd_ready;
  // A real slave response takes precedence over a watchdog expiry in the same cycle.
  assign w_rsp_fire = (r_state == ST_RSP) && (i_s_rsp_valid || w_timeout);
  assign w_rsp_err  = i_s_rsp_valid ? i_s_rsp_err : 1'b1;
  assign w_rsp_rdata = i_s_rsp_valid ? i_s_rsp_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= M_LSU;
      r_rr_last     <= M_IFU;
      r_s_cmd_valid <= 1'b0;
      r_s_cmd_addr  <= '0;
      r_s_cmd_read  <= 1'b0;
      r_s_cmd_wdata <= '0;
      r_s_cmd_wmask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_grant       <= w_gnt[1];
            r_s_cmd_valid <= 1'b1;
            r_s_cmd_addr  <= w_gnt[1] ? i_m1_cmd_addr  : i_m0_cmd_addr;
            r_s_cmd_read  <= w_gnt[1] ? i_m1_cmd_read  : i_m0_cmd_read;
            r_s_cmd_wdata <= w_gnt[1] ? i_m1_cmd_wdata : i_m0_cmd_wdata;
            r_s_cmd_wmask <= w_gnt[1] ? i_m1_cmd_wmask : i_m0_cmd_wmask;
            r_state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_s_cmd_ready) begin
            r_s_cmd_valid <= 1'b0;
            r_state       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (w_rsp_fire) begin
            r_rr_last <= r_grant;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog: counts RSP cycles from the slave accept; fires on the TIMEOUT-th
  // cycle after the accept. Saturates instead of wrapping.
  if (TIMEOUT > 0) begin : g_wdog
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_timer <= '0;
      end else if (w_accept) begin
        r_timer <= '0;
      end else if ((r_state == ST_RSP) && (r_timer != TO_MAX)) begin
        r_timer <= r_timer + 1'b1;
      end
    end

    assign w_timeout = (r_state == ST_RSP) && (r_timer >= TO_LAST);
  end else begin : g_no_wdog
    assign w_timeout = 1'b0;
  end

  assign o_s_cmd_valid = r_s_cmd_valid;
  assign o_s_cmd_addr  = r_s_cmd_addr;
  assign o_s_cmd_read  = r_s_cmd_read;
  assign o_s_cmd_wdata = r_s_cmd_wdata;
  assign o_s_cmd_wmask = r_s_cmd_wmask;

  assign o_m0_cmd_ready = w_accept && (r_grant == M_LSU);
  assign o_m1_cmd_ready = w_accept && (r_grant == M_IFU);

  assign o_m0_rsp_valid = w_rsp_fire && (r_grant == M_LSU);
  assign o_m0_rsp_err   = o_m0_rsp_valid && w_rsp_err;
  assign o_m0_rsp_rdata = {DW{o_m0_rsp_valid}} & w_rsp_rdata;
  assign o_m1_rsp_valid = w_rsp_fire && (r_grant == M_IFU);
  assign o_m1_rsp_err   = o_m1_rsp_valid && w_rsp_err;
  assign o_m1_rsp_rdata = {DW{o_m1_rsp_valid}} & w_rsp_rdata;

endmodule
